dmem_access_arbiter: RTL and testbench

Shares one byte-wide, single-port synchronous data memory (2**ADDR_W x 8) between two requesters: port 0 is the core load/store unit and port 1 is the debug/program loader.
- Accepts word, half or byte requests over a valid/ready handshake.
- Sequences the request as one byte access per cycle, little-endian.
- Returns read data or write completion on a one-cycle response pulse.
- Sits between the core's MEM stage and the data memory array.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_access_arbiter_rr_arbiter2.sv | 33 +++
 rtl/dmem_access_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dmem_access_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory access arbiter.
// Size encodings, FSM states and the size-to-byte-count helper.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_RESP
    } state_t;

    // 1x = word, 01 = half, 00 = byte
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        return size[1] ? 3'd4 : (size[0] ? 3'd2 : 3'd1);
    endfunction

endpackage

// File: rtl/dmem_access_arbiter_rr_arbiter2.sv
// Two-request round-robin grant: with both requesting, the port not served last wins.
// Ports: req (2), update strobe + served port index, gnt (one-hot or zero).
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic [1:0] gnt
);

    // Resets to 1 so that port 0 wins the first contested grant
    logic last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= served;
        end
    end

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares a byte-wide sync memory between the LSU (port 0) and debug loader (port 1).
// Ports: req/resp handshake per port; mem_en/we/addr/wdata/rdata to the byte array.
module dmem_access_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [1:0]        req0_size,
    input  logic [31:0]       req0_addr,
    input  logic [31:0]       req0_wdata,
    output logic              resp0_valid,
    output logic [31:0]       resp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [1:0]        req1_size,
    input  logic [31:0]       req1_addr,
    input  logic [31:0]       req1_wdata,
    output logic              resp1_valid,
    output logic [31:0]       resp1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_t            state_q;
    logic              port_q;
    logic              we_q;
    logic [2:0]        n_q;
    logic [1:0]        k_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rbuf_q;

    logic [1:0]  gnt;
    logic        sel;
    logic        idle;
    logic        accept;
    logic        g_we;
    logic [1:0]  g_size;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [1:0]  k_nxt;
    logic [1:0]  k_prev;
    logic        last;
    logic [31:0] rd_prev;
    logic [31:0] rd_cur;
    logic        unused_hi;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1_valid, req0_valid}),
        .update (state_q == S_RESP),
        .served (port_q),
        .gnt    (gnt)
    );

    assign idle = (state_q == S_IDLE);
    // Gated by rst_n so ready reads 0 while reset is held
    assign req0_ready = rst_n & idle & gnt[0];
    assign req1_ready = rst_n & idle & gnt[1];
    assign accept = req0_ready | req1_ready;

    assign sel     = gnt[1];
    assign g_we    = sel ? req1_we    : req0_we;
    assign g_size  = sel ? req1_size  : req0_size;
    assign g_addr  = sel ? req1_addr  : req0_addr;
    assign g_wdata = sel ? req1_wdata : req0_wdata;

    assign k_nxt  = k_q + 2'd1;
    assign k_prev = k_q - 2'd1;
    assign last   = ({1'b0, k_q} == n_q - 3'd1);

    // Read data lags its issue by one cycle, so ISSUE captures byte k-1
    assign rd_prev = 32'(mem_rdata) << {k_prev, 3'b000};
    assign rd_cur  = 32'(mem_rdata) << {k_q, 3'b000};

    assign unused_hi = ^{req0_addr[31:ADDR_W], req1_addr[31:ADDR_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            n_q         <= 3'd1;
            k_q         <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_rdata <= '0;
            resp1_rdata <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        port_q    <= sel;
                        we_q      <= g_we;
                        n_q       <= size_to_bytes(g_size);
                        k_q       <= 2'd0;
                        addr_q    <= g_addr[ADDR_W-1:0];
                        wdata_q   <= g_wdata;
                        rbuf_q    <= '0;
                        mem_en    <= 1'b1;
                        mem_we    <= g_we;
                        mem_addr  <= g_addr[ADDR_W-1:0];
                        mem_wdata <= g_wdata[7:0];
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!we_q && k_q != 2'd0) begin
                        rbuf_q <= rbuf_q | rd_prev;
                    end
                    if (last) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (we_q) begin
                            if (port_q) begin
                                resp1_valid <= 1'b1;
                                resp1_rdata <= '0;
                            end else begin
                                resp0_valid <= 1'b1;
                                resp0_rdata <= '0;
                            end
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end else begin
                        k_q       <= k_nxt;
                        mem_addr  <= addr_q + ADDR_W'(k_nxt);
                        mem_wdata <= 8'(wdata_q >> {k_nxt, 3'b000});
                    end
                end
                S_DRAIN: begin
                    if (port_q) begin
                        resp1_valid <= 1'b1;
                        resp1_rdata <= rbuf_q | rd_cur;
                    end else begin
                        resp0_valid <= 1'b1;
                        resp0_rdata <= rbuf_q | rd_cur;
                    end
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    resp0_valid <= 1'b0;
                    resp1_valid <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Directed bench for dmem_access_arbiter with a byte-array memory model.
// Checks latency, data, arbitration order, address wrap and mid-op reset.
module tb_dmem_access_arbiter;
    import dmem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we;
    logic [1:0]  req0_size;
    logic [31:0] req0_addr, req0_wdata;
    logic        resp0_valid;
    logic [31:0] resp0_rdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [1:0]  req1_size;
    logic [31:0] req1_addr, req1_wdata;
    logic        resp1_valid;
    logic [31:0] resp1_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0] mem [0:65535];
    int cyc = 0;
    int nvec = 0;
    int nbad = 0;
    int both_rdy = 0;
    int n_resp0 = 0;
    int n_resp1 = 0;
    int n_acc1 = 0;
    int acc_log[$];

    dmem_access_arbiter #(.ADDR_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_we     (req0_we),
        .req0_size   (req0_size),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .resp0_valid (resp0_valid),
        .resp0_rdata (resp0_rdata),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_we     (req1_we),
        .req1_size   (req1_size),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .resp1_valid (resp1_valid),
        .resp1_rdata (resp1_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        #2;
        if (req0_ready && req1_ready) both_rdy++;
        if (req0_ready) acc_log.push_back(0);
        if (req1_ready) begin
            acc_log.push_back(1);
            n_acc1++;
        end
        if (resp0_valid) n_resp0++;
        if (resp1_valid) n_resp1++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic we,
                            input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd);
        if (p == 0) begin
            req0_valid = v; req0_we = we; req0_size = sz;
            req0_addr = a; req0_wdata = wd;
        end else begin
            req1_valid = v; req1_we = we; req1_size = sz;
            req1_addr = a; req1_wdata = wd;
        end
    endtask

    task automatic xfer(input int p, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
        int t0;
        bit ok;
        @(negedge clk);
        set_port(p, 1'b1, we, sz, a, wd);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if ((p == 0) ? req0_ready : req1_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        t0 = cyc;
        chk($sformatf("p%0d_accept", p), 32'(ok), 32'd1);
        @(negedge clk);
        if (p == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((p == 0) ? resp0_valid : resp1_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("p%0d_resp", p), 32'(ok), 32'd1);
        lat = cyc - t0;
        rd = (p == 0) ? resp0_rdata : resp1_rdata;
    endtask

    logic [31:0] rd;
    int lat, t1, t2, r0, a1, s1;
    bit ok;
    logic [3:0] gpat;

    initial begin
        rst_n = 1'b0;
        set_port(0, 1'b0, 1'b0, SZ_BYTE, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, SZ_BYTE, 32'h0, 32'h0);
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
        chk("rst_resp", 32'({resp1_valid, resp0_valid}), 32'd0);
        chk("rst_rdata0", resp0_rdata, 32'd0);
        chk("rst_rdata1", resp1_rdata, 32'd0);
        chk("rst_mem", 32'({mem_en, mem_we, mem_wdata, mem_addr}), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // both ports contend from reset release
        fork
            begin : p0
                logic [31:0] d0;
                int l0;
                xfer(0, 1'b1, SZ_WORD, 32'h500, 32'h11111111, d0, l0);
                chk("arb_p0_st_lat", 32'(l0), 32'd5);
                xfer(0, 1'b0, SZ_WORD, 32'h500, 32'h0, d0, l0);
                chk("arb_p0_ld", d0, 32'h11111111);
            end
            begin : p1
                logic [31:0] d1;
                int l1;
                xfer(1, 1'b1, SZ_HALF, 32'h600, 32'h00002222, d1, l1);
                chk("arb_p1_st_lat", 32'(l1), 32'd3);
                xfer(1, 1'b0, SZ_HALF, 32'h600, 32'h0, d1, l1);
                chk("arb_p1_ld", d1, 32'h00002222);
                chk("arb_p1_ld_lat", 32'(l1), 32'd4);
            end
        join
        repeat (2) @(negedge clk);
        chk("arb_count", 32'(acc_log.size()), 32'd4);
        gpat = 4'b0;
        for (int i = 0; i < 4; i++)
            if (i < acc_log.size()) gpat[i] = acc_log[i][0];
        chk("arb_order", 32'(gpat), 32'b1010);
        chk("arb_both_ready", 32'(both_rdy), 32'd0);
        chk("arb_resp0_cnt", 32'(n_resp0), 32'd2);
        chk("arb_resp1_cnt", 32'(n_resp1), 32'd2);

        // word store then load
        xfer(0, 1'b1, SZ_WORD, 32'h0100, 32'hDEADBEEF, rd, lat);
        chk("st_word_lat", 32'(lat), 32'd5);
        chk("st_rdata", rd, 32'd0);
        chk("st_word_mem", {mem[16'h103], mem[16'h102], mem[16'h101],
                            mem[16'h100]}, 32'hDEADBEEF);
        xfer(0, 1'b0, SZ_WORD, 32'h0100, 32'h0, rd, lat);
        chk("ld_word", rd, 32'hDEADBEEF);
        chk("ld_word_lat", 32'(lat), 32'd6);

        // byte / half / misaligned loads
        mem[16'h200] = 8'h11; mem[16'h201] = 8'h22;
        mem[16'h202] = 8'h33; mem[16'h203] = 8'h44;
        mem[16'h204] = 8'h55;
        xfer(0, 1'b0, SZ_BYTE, 32'h0201, 32'h0, rd, lat);
        chk("ld_byte", rd, 32'h00000022);
        chk("ld_byte_lat", 32'(lat), 32'd3);
        xfer(0, 1'b0, SZ_HALF, 32'h0202, 32'h0, rd, lat);
        chk("ld_half", rd, 32'h00004433);
        chk("ld_half_lat", 32'(lat), 32'd4);
        xfer(1, 1'b0, SZ_HALF, 32'h0203, 32'h0, rd, lat);
        chk("ld_half_mis", rd, 32'h00005544);
        xfer(1, 1'b0, SZ_WORD, 32'h0201, 32'h0, rd, lat);
        chk("ld_word_mis", rd, 32'h55443322);

        // address wrap with upper bits set
        xfer(0, 1'b1, SZ_WORD, 32'hABCDFFFE, 32'h01020304, rd, lat);
        chk("wrap_mem", {mem[16'h0001], mem[16'h0000], mem[16'hFFFF],
                         mem[16'hFFFE]}, 32'h01020304);
        xfer(0, 1'b0, SZ_WORD, 32'h1234FFFE, 32'h0, rd, lat);
        chk("wrap_ld", rd, 32'h01020304);

        // back-to-back on port 1 with valid held across its response
        a1 = n_acc1;
        s1 = n_resp1;
        @(negedge clk);
        set_port(1, 1'b1, 1'b1, SZ_BYTE, 32'h0300, 32'h00000055);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req1_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        t1 = cyc;
        chk("b2b_acc1", 32'(ok), 32'd1);
        @(negedge clk);
        set_port(1, 1'b1, 1'b1, SZ_BYTE, 32'h0301, 32'h00000066);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req1_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        t2 = cyc;
        chk("b2b_acc2", 32'(ok), 32'd1);
        chk("b2b_gap", 32'(t2 - t1), 32'd3);
        @(negedge clk);
        req1_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_mem", {16'h0, mem[16'h301], mem[16'h300]}, 32'h00006655);
        chk("b2b_accepts", 32'(n_acc1 - a1), 32'd2);
        chk("b2b_resps", 32'(n_resp1 - s1), 32'd2);
        chk("rdata_hold", resp0_rdata, 32'h01020304);

        // reset in the middle of a word store, after two bytes
        @(negedge clk);
        set_port(0, 1'b1, 1'b1, SZ_WORD, 32'h0400, 32'hA1B2C3D4);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("rst_op_acc", 32'(ok), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        r0 = n_resp0;
        rst_n = 1'b0;
        #1;
        chk("rst_op_mem", 32'({mem_en, mem_we, mem_wdata, mem_addr}), 32'd0);
        chk("rst_op_resp", 32'({resp1_valid, resp0_valid}), 32'd0);
        chk("rst_op_rdata0", resp0_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_op_bytes", {mem[16'h403], mem[16'h402], mem[16'h401],
                             mem[16'h400]}, 32'h0000C3D4);
        chk("rst_op_noresp", 32'(n_resp0 - r0), 32'd0);
        xfer(0, 1'b0, SZ_WORD, 32'h0400, 32'h0, rd, lat);
        chk("post_rst_ld", rd, 32'h0000C3D4);
        chk("post_rst_lat", 32'(lat), 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
